// File: rtl/sum_datapath.sv
// rtl/sum_datapath.sv - summation datapath: down-counter, accumulator and result register
// Executes the {m1,m0} command from the control FSM every cycle; nill reports cnt == 0.
module sum_datapath #(
  parameter int WIDTH     = 8,
  parameter int ACC_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 m0,
  input  logic                 m1,
  input  logic [WIDTH-1:0]     n_in,
  output logic                 nill,
  output logic [ACC_WIDTH-1:0] result,
  output logic                 done,
  output logic                 overflow
);

  typedef enum logic [1:0] {
    CMD_HOLD  = 2'b00,
    CMD_LOAD  = 2'b01,
    CMD_ACCUM = 2'b10,
    CMD_STORE = 2'b11
  } cmd_e;

  cmd_e                 cmd;
  logic [WIDTH-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] result_q, result_d;
  logic                 done_q, done_d;
  logic                 overflow_q, overflow_d;
  logic [ACC_WIDTH:0]   sum_full;

  assign cmd = cmd_e'({m1, m0});

  // One extra bit captures the carry out of the accumulator.
  assign sum_full = {1'b0, acc_q} + (ACC_WIDTH + 1)'(cnt_q);

  always_comb begin
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    result_d   = result_q;
    done_d     = 1'b0;
    overflow_d = overflow_q;
    case (cmd)
      CMD_LOAD: begin
        cnt_d      = n_in;
        acc_d      = '0;
        overflow_d = 1'b0;
      end
      CMD_ACCUM: begin
        if (cnt_q != '0) begin
          acc_d = sum_full[ACC_WIDTH-1:0];
          cnt_d = cnt_q - WIDTH'(1);
          if (sum_full[ACC_WIDTH]) overflow_d = 1'b1;
        end
      end
      CMD_STORE: begin
        result_d = acc_q;
        done_d   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      done_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      done_q     <= done_d;
      overflow_q <= overflow_d;
    end
  end

  assign nill     = (cnt_q == '0);
  assign result   = result_q;
  assign done     = done_q;
  assign overflow = overflow_q;

endmodule

// File: doc/sum_datapath.md
# sum_datapath

Datapath slave for the summation unit: computes S = N + (N-1) + … + 1 under direct command of the two-bit control word (m1, m0) driven by the summation control FSM. It returns the `nill` status flag that the FSM uses for sequencing. It holds the down-counter, the accumulator and the result register. All sequencing decisions stay in the FSM; this block only executes the decoded command each cycle.

## Interface
- WIDTH, 8, width of operand N and of the down-counter
- ACC_WIDTH, 16, width of accumulator and result (must be ≥ WIDTH)
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  reset; one clock; reset is synchronous and active-high
- m0  input  1  control word bit 0 from the FSM
- m1  input  1  control word bit 1 from the FSM
- n_in  input  WIDTH  operand N, sampled only on LOAD
- nill  output  1  high when down-counter == 0 (combinational from counter register)
- result  output  ACC_WIDTH  last latched sum
- done  output  1  one-cycle pulse when result is latched
- overflow  output  1  sticky: accumulator wrapped since last LOAD

## Operation
- Command decode {m1,m0}:
  - 00 HOLD: all registers keep value.
  - 01 LOAD: cnt ← n_in; acc ← 0; overflow ← 0.
  - 10 ACCUM: if cnt ≠ 0, then acc ← acc + zero-extended cnt (mod 2^ACC_WIDTH) and cnt ← cnt − 1. If cnt == 0, acc and cnt are unchanged; there is no underflow wrap.
  - 11 STORE: result ← acc; done ← 1 for that cycle. cnt, acc and overflow are unchanged.
- overflow is set on any ACCUM whose true sum exceeds 2^ACC_WIDTH − 1. It stays set until LOAD or rst. A LOAD in the same cycle clears it.
- done is 0 in every cycle whose registered command was not STORE.
- nill = (cnt == 0). It has no register of its own and reflects the counter register directly.
- Commands are fully decoded each cycle. The block has no internal state machine and no protection against illegal sequences. For example, ACCUM before any LOAD operates on the reset values.
- Reset values: cnt = 0 (so nill = 1), acc = 0, result = 0, done = 0, overflow = 0.
- rst has priority over any command in the same cycle. Asserting rst mid-accumulation discards partial sums; result returns to 0.

## Timing
- Command at edge k takes effect at edge k. New register values are visible after edge k.
- nill follows cnt with zero cycles of combinational delay. The FSM samples it at the next edge.
- Normal sequence for N: LOAD (1 cycle), ACCUM ×N cycles, then nill = 1, STORE (1 cycle). Total N+2 cycles from LOAD edge to result-valid edge.
- N = 0: nill is high right after the LOAD edge, and STORE latches 0.
- done is asserted for exactly the cycle after the STORE edge and is high together with the new result.
- Back-to-back STORE: result is rewritten with an unchanged acc, and done stays high on consecutive cycles.
- LOAD directly after STORE is legal: result holds while the new sum accumulates.
- Width rule: cnt is zero-extended to ACC_WIDTH before addition. Carry out of bit ACC_WIDTH−1 sets overflow.

## Test plan
- rst pulse, then HOLD -> nill=1, result=0, done=0, overflow=0; all stay constant under HOLD.
- n_in=5, LOAD, ACCUM until nill, STORE -> nill rises after 5th ACCUM; result=15, done pulse 1 cycle, overflow=0.
- n_in=0, LOAD, STORE -> nill=1 immediately after LOAD, result=0; extra ACCUM while nill=1 leaves acc=0.
- Defaults, n_in=255 full run -> result=32640, overflow=0; ACC_WIDTH=8, n_in=30 -> result=209 (465 mod 256), overflow=1; subsequent LOAD clears overflow.
- n_in=10, LOAD, 4 ACCUM (acc=34), rst high 1 cycle -> all outputs at reset values, nill=1; new LOAD n_in=3 full run -> result=6.
- Two STOREs in a row after N=4 run -> result=10 both cycles, done high 2 cycles; HOLD inserted between ACCUMs does not alter the final 10.
